// File: rtl/key_event_scanner_if.sv
// Event stream between the key scanner and the MCU: show-ahead valid/ready
// plus the sticky overflow flag and its clear.
interface key_event_scanner_if #(
    parameter int CODE_W = 4
) ();
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_ready;
    logic              evt_overflow;
    logic              ovf_clr;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_overflow,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_overflow,
        output evt_ready,
        output ovf_clr
    );
endinterface

// File: rtl/key_event_scanner.sv
// Multi-key debouncer producing press/release/long/repeat pulses, with the
// pulses serialised through per-key pending flags into a show-ahead event FIFO.
module key_event_scanner #(
    parameter int NUM_KEYS        = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_stable,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    key_event_scanner_if.master evt
);
    localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CODE_W = IDX_W + 2;
    localparam int FLAGS  = 4 * NUM_KEYS;
    localparam int DW     = $clog2(DEBOUNCE_CYCLES);
    localparam int HW     = $clog2(LONG_CYCLES + REPEAT_CYCLES + 2);
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [NUM_KEYS-1:0] IDLE_LEVEL =
        (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_TOP  = HW'(LONG_CYCLES + REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_WRAP = HW'(LONG_CYCLES + 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] accept;
    logic [DW-1:0]       dcnt [NUM_KEYS];
    logic [HW-1:0]       hold [NUM_KEYS];

    logic [FLAGS-1:0]    pend;
    logic [FLAGS-1:0]    pulse_vec;
    logic [FLAGS-1:0]    clr_vec;
    logic                sel_found;
    logic [CODE_W-1:0]   sel_idx;
    logic [CODE_W-1:0]   sel_code;
    logic                ovf_new;
    logic                ovf;

    logic [CODE_W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]         wp;
    logic [AW:0]         rp;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    // Synchronisers reset to the released level so reset exit is silent.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_comb begin
        accept = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            accept[k] = (pressed[k] != key_stable[k]) && (dcnt[k] == DEB_LAST);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_stable  <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                dcnt[k] <= '0;
                hold[k] <= '0;
            end
        end else begin
            key_press   <= accept & pressed;
            key_release <= accept & ~pressed;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (accept[k]) begin
                    dcnt[k]       <= '0;
                    key_stable[k] <= pressed[k];
                end else if (pressed[k] != key_stable[k]) begin
                    dcnt[k] <= dcnt[k] + 1'b1;
                end else begin
                    dcnt[k] <= '0;
                end

                // Hold counter wraps to LONG+1 after each repeat to stay bounded.
                if (accept[k] && pressed[k]) begin
                    hold[k] <= '0;
                end else if (key_stable[k]) begin
                    if (REPEAT_CYCLES == 0) begin
                        if (hold[k] <= HOLD_LONG) begin
                            hold[k] <= hold[k] + 1'b1;
                        end
                    end else if (hold[k] == HOLD_TOP) begin
                        hold[k] <= HOLD_WRAP;
                    end else begin
                        hold[k] <= hold[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        key_long   = '0;
        key_repeat = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            key_long[k]   = key_stable[k] && (hold[k] == HOLD_LONG);
            key_repeat[k] = (REPEAT_CYCLES != 0) && key_stable[k] && (hold[k] == HOLD_TOP);
        end
    end

    // Flag layout: bit 4*key + type, type 0 press, 1 release, 2 long, 3 repeat.
    always_comb begin
        pulse_vec = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            pulse_vec[4*k]     = key_press[k];
            pulse_vec[4*k + 1] = key_release[k];
            pulse_vec[4*k + 2] = key_long[k];
            pulse_vec[4*k + 3] = key_repeat[k];
        end
    end

    // Lowest set bit wins, which is lowest key first, then press..repeat.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = FLAGS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_found = 1'b1;
                sel_idx   = CODE_W'(i);
            end
        end
        sel_code = {sel_idx[1:0], sel_idx[CODE_W-1:2]};
    end

    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = (wp == rp);
    assign push    = sel_found && !full;
    assign pop     = !empty && evt.evt_ready;
    assign clr_vec = push ? ({{(FLAGS-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign ovf_new = |(pulse_vec & pend & ~clr_vec);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend <= '0;
            ovf  <= 1'b0;
            wp   <= '0;
            rp   <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                mem[d] <= '0;
            end
        end else begin
            pend <= (pend & ~clr_vec) | pulse_vec;
            if (ovf_new) begin
                ovf <= 1'b1;
            end else if (evt.ovf_clr) begin
                ovf <= 1'b0;
            end
            if (push) begin
                mem[wp[AW-1:0]] <= sel_code;
                wp              <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    assign evt.evt_valid    = !empty;
    assign evt.evt_code     = mem[rp[AW-1:0]];
    assign evt.evt_overflow = ovf;
endmodule
